// File: rtl/vx_mat_pack_fifo_if.sv
// Handshake bundle for the matrix packing FIFO: element input side,
// row output side and occupancy status.
interface vx_mat_pack_fifo_if #(
  parameter int ELEM_WIDTH = 8,
  parameter int WORD_WIDTH = 32,
  parameter int NUM_REGS   = 4,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                           i_valid;
  logic                           o_ready;
  logic [ELEM_WIDTH-1:0]          i_data;
  logic                           i_flush;
  logic                           o_valid;
  logic                           i_ready;
  logic [NUM_REGS*WORD_WIDTH-1:0] o_data;
  logic [CW-1:0]                  o_count;
  logic                           o_full;
  logic                           o_empty;

  // producer/consumer side
  modport master (
    output i_valid, i_data, i_flush, i_ready,
    input  o_ready, o_valid, o_data, o_count, o_full, o_empty
  );

  // FIFO side
  modport slave (
    input  i_valid, i_data, i_flush, i_ready,
    output o_ready, o_valid, o_data, o_count, o_full, o_empty
  );
endinterface

// File: rtl/vx_mat_pack_fifo.sv
// Packing FIFO: narrow elements are packed in place into the entry at wr_ptr
// until a row fills or a flush closes it; committed rows are read from rd_ptr.
module vx_mat_pack_fifo #(
  parameter int ELEM_WIDTH = 8,
  parameter int WORD_WIDTH = 32,
  parameter int NUM_REGS   = 4,
  parameter int DEPTH      = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  vx_mat_pack_fifo_if.slave       bus
);
  localparam int EPW = WORD_WIDTH / ELEM_WIDTH;
  localparam int EPR = EPW * NUM_REGS;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int FW  = (EPR > 1) ? $clog2(EPR) : 1;
  localparam int RW  = NUM_REGS * WORD_WIDTH;
  localparam logic [FW-1:0] FILL_LAST = FW'(EPR - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  logic [RW-1:0] storage_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [RW-1:0] row_d;
  logic          full;
  logic          accept;
  logic          pop;
  logic          commit;

  assign full   = (count_q == COUNT_MAX);
  assign accept = bus.i_valid & ~full;
  assign pop    = bus.i_ready & (count_q != '0);
  // A flush only closes a row that holds at least one element, counting one
  // accepted this very cycle. While full no row is open, so flush is inert.
  assign commit = (accept & (fill_q == FILL_LAST)) |
                  (bus.i_flush & ((fill_q != '0) | accept));

  // Next-state for pointers, occupancy, fill index and the row being assembled.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    count_d  = count_q + CW'(commit) - CW'(pop);
    row_d    = storage_q[wr_ptr_q];
    if (fill_q == '0) row_d = '0;
    row_d[int'(fill_q)*ELEM_WIDTH +: ELEM_WIDTH] = bus.i_data;
    if (commit) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      fill_d   = '0;
    end else if (accept) begin
      fill_d = fill_q + FW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Control registers; reset drops any partially packed row.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fill_q   <= fill_d;
    end
  end

  // Row storage; element 0 of a row also clears the stale lanes of the entry.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) storage_q[i] <= '0;
    end else if (accept) begin
      storage_q[wr_ptr_q] <= row_d;
    end
  end

  assign bus.o_ready = ~full;
  assign bus.o_valid = (count_q != '0);
  assign bus.o_data  = storage_q[rd_ptr_q];
  assign bus.o_count = count_q;
  assign bus.o_full  = full;
  assign bus.o_empty = (count_q == '0);
endmodule
